// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg: minimal CCI-P channel-0 request header type used by the TX skid FIFO.
package ccip_if_pkg;
  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;
endpackage

// File: rtl/ofs_plat_ccip_skid_pkg.sv
// ofs_plat_ccip_skid_pkg: derived widths and parameter legality for the c0 TX skid FIFO.
package ofs_plat_ccip_skid_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic bit params_ok(input int depth, input int slack);
    return depth >= 4 && (depth & (depth - 1)) == 0 && slack >= 1 && slack <= depth - 1;
  endfunction
endpackage

// File: rtl/ofs_plat_ccip_skid_mem.sv
// ofs_plat_ccip_skid_mem: simple dual-port RAM with one write port and a registered read port.
module ofs_plat_ccip_skid_mem
  import ofs_plat_ccip_skid_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // Same-address read and write return the old entry, which the full push+pop case relies on.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end
endmodule

// File: rtl/ofs_plat_ccip_c0_tx_skid_fifo.sv
// ofs_plat_ccip_c0_tx_skid_fifo: absorbs late c0 TX requests and meters them out while the FIU is not almost full.
module ofs_plat_ccip_c0_tx_skid_fifo
  import ofs_plat_ccip_skid_pkg::*;
#(
  parameter int HDR_WIDTH     = $bits(ccip_if_pkg::t_ccip_c0_ReqMemHdr),
  parameter int DEPTH         = 64,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [HDR_WIDTH-1:0]      in_hdr,
  output logic                      in_almfull,
  output logic                      out_valid,
  output logic [HDR_WIDTH-1:0]      out_hdr,
  input  logic                      fiu_almfull,
  output logic [cnt_w(DEPTH)-1:0]   occupancy,
  output logic                      overflow
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - ALMFULL_SLACK);
  if (!params_ok(DEPTH, ALMFULL_SLACK)) begin : g_bad_params
    $error("ofs_plat_ccip_c0_tx_skid_fifo: DEPTH must be a power of 2 >= 4 and ALMFULL_SLACK in 1..DEPTH-1");
  end
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic push, pop, accept, almfull_q, valid_q, ovf_q;
  // Pop decisions use the registered count, so a fresh entry is never read in its write cycle.
  always_comb begin
    push    = !reset && in_valid;
    pop     = !reset && count_q != '0 && !fiu_almfull;
    accept  = push && (count_q != FULL || pop);
    count_d = count_q + CW'(accept) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      almfull_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q  <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      valid_q   <= pop;
      ovf_q     <= ovf_q | (push & !accept);
      almfull_q <= count_d >= THRESH;
    end
  end
  ofs_plat_ccip_skid_mem #(
    .DEPTH (DEPTH),
    .WIDTH (HDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (in_hdr),
    .rd_en   (pop),
    .rd_addr (rd_ptr_q),
    .rd_data (out_hdr)
  );
  assign in_almfull = almfull_q;
  assign out_valid  = valid_q;
  assign occupancy  = count_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_ofs_plat_ccip_c0_tx_skid_fifo.sv
// tb_ofs_plat_ccip_c0_tx_skid_fifo: table vectors, corner sequences and a random stream against a queue model.
module tb_ofs_plat_ccip_c0_tx_skid_fifo;
  localparam int HW = $bits(ccip_if_pkg::t_ccip_c0_ReqMemHdr);
  localparam int DEPTH = 64;
  localparam int SLACK = 8;
  logic clk = 1'b0;
  logic reset, in_valid, fiu_almfull;
  logic [HW-1:0] in_hdr;
  logic in_almfull, out_valid, overflow;
  logic [HW-1:0] out_hdr;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  int checks = 0;
  int errors = 0;
  logic [HW-1:0] mq[$];
  logic [HW-1:0] rx[$];
  logic [HW-1:0] sent[$];
  logic m_valid, m_hdr_known, m_almf, m_ovf;
  logic [HW-1:0] m_hdr;
  typedef struct {
    logic r, iv;
    logic [15:0] h;
    logic fa, ev;
    logic [15:0] eh;
    int eocc;
    logic ealm, eovf, ch;
  } vec_t;
  vec_t tbl[11];
  ofs_plat_ccip_c0_tx_skid_fifo #(
    .HDR_WIDTH     (HW),
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (SLACK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_hdr      (in_hdr),
    .in_almfull  (in_almfull),
    .out_valid   (out_valid),
    .out_hdr     (out_hdr),
    .fiu_almfull (fiu_almfull),
    .occupancy   (occupancy),
    .overflow    (overflow)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction
  task automatic step(input logic r, input logic iv, input logic [HW-1:0] h, input logic fa);
    reset = r;
    in_valid = iv;
    in_hdr = h;
    fiu_almfull = fa;
    if (r) begin
      mq.delete();
      m_valid = 1'b0;
      m_hdr_known = 1'b0;
      m_almf = 1'b1;
      m_ovf = 1'b0;
    end else begin
      m_valid = mq.size() != 0 && !fa;
      if (m_valid) begin
        m_hdr = mq.pop_front();
        m_hdr_known = 1'b1;
      end
      if (iv) begin
        if (mq.size() < DEPTH) mq.push_back(h);
        else m_ovf = 1'b1;
      end
      m_almf = mq.size() >= DEPTH - SLACK;
    end
    @(posedge clk);
    #1;
    chk("model_out_valid", out_valid, m_valid);
    if (m_hdr_known) chk("model_out_hdr", out_hdr, m_hdr);
    chk("model_occupancy", occupancy, mq.size());
    chk("model_in_almfull", in_almfull, m_almf);
    chk("model_overflow", overflow, m_ovf);
    if (out_valid === 1'b1) rx.push_back(out_hdr);
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_hdr = '0;
    fiu_almfull = 1'b0;
    tbl[0]  = '{1, 0, 16'h000, 0, 0, 16'h000, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 16'h123, 0, 0, 16'h000, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 16'h000, 0, 1, 16'h123, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 16'h000, 0, 0, 16'h123, 0, 0, 0, 1};
    tbl[4]  = '{0, 1, 16'h0AA, 1, 0, 16'h123, 1, 0, 0, 1};
    tbl[5]  = '{0, 1, 16'h0BB, 1, 0, 16'h123, 2, 0, 0, 1};
    tbl[6]  = '{0, 0, 16'h000, 0, 1, 16'h0AA, 1, 0, 0, 1};
    tbl[7]  = '{0, 1, 16'h0CC, 0, 1, 16'h0BB, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 16'h000, 1, 0, 16'h0BB, 1, 0, 0, 1};
    tbl[9]  = '{0, 0, 16'h000, 0, 1, 16'h0CC, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 16'h000, 0, 0, 16'h0CC, 0, 0, 0, 1};
    step(1, 0, '0, 0);
    step(1, 1, HW'(16'h777), 0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].iv, HW'(tbl[i].h), tbl[i].fa);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ch) chk($sformatf("tbl%0d_hdr", i), out_hdr, HW'(tbl[i].eh));
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].eocc);
      chk($sformatf("tbl%0d_almfull", i), in_almfull, tbl[i].ealm);
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].eovf);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, HW'(32'h200 + i), 1);
      chk("stall_no_valid", out_valid, 1'b0);
    end
    chk("stall_occ", occupancy, 10);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, 0);
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_hdr", out_hdr, HW'(32'h200 + i));
    end
    step(0, 0, '0, 0);
    chk("drain_done", out_valid, 1'b0);
    for (int i = 0; i < 55; i++) step(0, 1, HW'(32'h300 + i), 1);
    chk("thr_55_almfull", in_almfull, 1'b0);
    step(0, 1, HW'(32'h337), 1);
    chk("thr_56_almfull", in_almfull, 1'b1);
    chk("thr_56_occ", occupancy, 56);
    step(0, 0, '0, 0);
    chk("thr_pop_almfull", in_almfull, 1'b0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, HW'(32'h400 + i), 1);
    chk("full_occ", occupancy, 64);
    chk("full_no_ovf", overflow, 1'b0);
    step(0, 1, HW'(32'h4FF), 0);
    chk("full_pushpop_occ", occupancy, 64);
    chk("full_pushpop_ovf", overflow, 1'b0);
    chk("full_pushpop_hdr", out_hdr, HW'(32'h400));
    step(0, 1, HW'(32'h4FE), 1);
    chk("full_drop_ovf", overflow, 1'b1);
    chk("full_drop_occ", occupancy, 64);
    step(0, 0, '0, 1);
    chk("ovf_sticky", overflow, 1'b1);
    step(1, 0, '0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, HW'(32'h500 + i), 1);
    chk("mid_occ20", occupancy, 20);
    step(1, 1, HW'(32'h5AA), 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_almfull", in_almfull, 1'b1);
    step(1, 1, HW'(32'h5AB), 0);
    step(0, 0, '0, 0);
    chk("mid_rel_almfull", in_almfull, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, 0);
      chk("mid_no_stale", out_valid, 1'b0);
    end
    rx.delete();
    sent.delete();
    begin
      int n = 0;
      int cyc = 0;
      while (n < 200 && cyc < 2000) begin
        logic iv, fa;
        iv = 1'($urandom_range(0, 1));
        fa = $urandom_range(0, 9) < 3;
        if (iv) begin
          step(0, 1, HW'(32'h1000 + n), fa);
          sent.push_back(HW'(32'h1000 + n));
          n++;
        end else step(0, 0, '0, fa);
        cyc++;
      end
      for (int k = 0; k < 200 && mq.size() != 0; k++) step(0, 0, '0, 0);
      chk("wrap_drained", mq.size(), 0);
      chk("wrap_count", rx.size(), 200);
      for (int i = 0; i < rx.size() && i < sent.size(); i++)
        if (rx[i] !== sent[i]) chk($sformatf("wrap_order%0d", i), rx[i], sent[i]);
      chk("wrap_no_ovf", overflow, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
